// File: rtl/td4_pkg.sv
// -----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 execution datapath:
//   TD4_DATA_W / TD4_PC_W : default data and program-counter widths
//   src_sel_e             : adder operand source encoding from the decoder
//   SEL_LOAD              : level of a load select that means "load this reg"
// -----------------------------------------------------------------------------
package td4_pkg;

  localparam int TD4_DATA_W = 4;
  localparam int TD4_PC_W   = 4;

  typedef enum logic [1:0] {
    SRC_A    = 2'b00,
    SRC_B    = 2'b01,
    SRC_IN   = 2'b10,
    SRC_ZERO = 2'b11
  } src_sel_e;

  // Decoder load selects are active-low.
  localparam logic SEL_LOAD = 1'b0;

endpackage

// File: rtl/td4_alu.sv
// -----------------------------------------------------------------------------
// td4_alu
// Combinational operand mux plus adder of the TD4 datapath.
// Ports:
//   src_sel  in   operand source (A, B, in_port, zero)
//   a, b     in   current A and B register values
//   in_port  in   external input port, used as-is (no synchronisation)
//   im       in   immediate field of the current instruction
//   result   out  DATA_W-bit sum, wraps modulo 2^DATA_W
//   cy       out  carry out of the DATA_W-bit add
// -----------------------------------------------------------------------------
module td4_alu
  import td4_pkg::*;
#(
  parameter int DATA_W = TD4_DATA_W
) (
  input  logic [1:0]        src_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] in_port,
  input  logic [DATA_W-1:0] im,
  output logic [DATA_W-1:0] result,
  output logic              cy
);

  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;

  always_comb begin
    operand = '0;
    case (src_sel_e'(src_sel))
      SRC_A:    operand = a;
      SRC_B:    operand = b;
      SRC_IN:   operand = in_port;
      SRC_ZERO: operand = '0;
      default:  operand = '0;
    endcase
    sum = {1'b0, operand} + {1'b0, im};
  end

  assign result = sum[DATA_W-1:0];
  assign cy     = sum[DATA_W];

endmodule

// File: rtl/td4_datapath.sv
// -----------------------------------------------------------------------------
// td4_datapath
// Architectural state (A, B, OUT, PC, carry) and execute step of the TD4 CPU.
// Every enabled clock edge executes one instruction: the ALU result is loaded
// into each register whose active-low select is asserted, PC either loads the
// result (jump) or increments, and the carry flag takes the adder carry.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   step              (TD4_STEP_EN only) asynchronous push-button level;
//                     each rising edge executes exactly one instruction
//   src_sel           adder operand source
//   sel_A/B/Out/PC    active-low load selects from the decoder
//   im, in_port       immediate field and external input
//   pc                program counter to ROM
//   out_port          OUT register
//   c                 registered carry flag back to the decoder
//   a_q, b_q          A and B registers for observation
// Optional feature: define TD4_STEP_EN to add single-step execution.
// -----------------------------------------------------------------------------
module td4_datapath
  import td4_pkg::*;
#(
  parameter int DATA_W = TD4_DATA_W,
  parameter int PC_W   = TD4_PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef TD4_STEP_EN
  input  logic              step,
`endif
  input  logic [1:0]        src_sel,
  input  logic              sel_A,
  input  logic              sel_B,
  input  logic              sel_Out,
  input  logic              sel_PC,
  input  logic [DATA_W-1:0] im,
  input  logic [DATA_W-1:0] in_port,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] out_port,
  output logic              c,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] result;
  logic              cy;
  logic              exec;

  logic [DATA_W-1:0] a_d, b_d, out_d, out_q;
  logic [PC_W-1:0]   pc_d, pc_q, pc_load;
  logic              c_d, c_q;
  logic [PC_W+DATA_W-1:0] result_ext;

  td4_alu #(.DATA_W(DATA_W)) u_alu (
    .src_sel (src_sel),
    .a       (a_q),
    .b       (b_q),
    .in_port (in_port),
    .im      (im),
    .result  (result),
    .cy      (cy)
  );

`ifdef TD4_STEP_EN
  // Two-flop synchroniser followed by a rising-edge detector.
  // vld_p1/vld_p2 mark when the synchroniser holds a real post-reset sample;
  // the previous-level flop resets high and only tracks real samples, so a
  // button held through reset release must fall and rise again to execute.
  logic step_s1_d, step_s1_q, step_s2_d, step_s2_q;
  logic step_prev_d, step_prev_q;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;

  always_comb begin
    step_s1_d   = step;
    step_s2_d   = step_s1_q;
    vld_p1_d    = 1'b1;
    vld_p2_d    = vld_p1_q;
    step_prev_d = vld_p2_q ? step_s2_q : step_prev_q;
    exec        = vld_p2_q & step_s2_q & ~step_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b1;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
    end else begin
      step_s1_q   <= step_s1_d;
      step_s2_q   <= step_s2_d;
      step_prev_q <= step_prev_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
    end
  end
`else
  assign exec = 1'b1;
`endif

  // Jump target: zero-extend or truncate the sum to PC_W.
  assign result_ext = {{PC_W{1'b0}}, result};
  assign pc_load    = result_ext[PC_W-1:0];

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    if (exec) begin
      if (sel_A   == SEL_LOAD) a_d   = result;
      if (sel_B   == SEL_LOAD) b_d   = result;
      if (sel_Out == SEL_LOAD) out_d = result;
      pc_d = (sel_PC == SEL_LOAD) ? pc_load : pc_q + PC_W'(1);
      c_d  = cy;
    end
  end

  // Execute stage boundary: architectural state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= '0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign pc       = pc_q;
  assign out_port = out_q;
  assign c        = c_q;

endmodule
